// File: rtl/z80_uart_pkg.sv
// Shared constants and state types for the Z80 memory-mapped UART.
package z80_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIVLO  = 2'd2;
    localparam logic [1:0] REG_DIVHI  = 2'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_OVERRUN  = 4;
    localparam int ST_TX_BUSY  = 5;
    localparam int ST_TX_DROP  = 6;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

    // Divisors below 2 would make the half-bit RX sample point zero.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; a pop frees a slot for a push in the same cycle.
module uart_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic                  do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/z80_uart_mmio.sv
// Memory-mapped 8N1 UART on one 256-byte Z80 page: TX/RX FIFOs, programmable divisor,
// read data registered with the same 1-cycle latency as RAM.
module z80_uart_mmio
    import z80_uart_pkg::*;
#(
    parameter logic [7:0]  PAGE            = 8'hFF,
    parameter logic [15:0] DIV_RESET       = 16'd217,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  o_data,
    input  logic        we,
    output logic [7:0]  rdata,
    output logic        hit,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);

    logic        sel, wstb, we_q;
    logic [15:0] addr_q;
    logic [1:0]  offset;
    logic        wr_data, wr_status, wr_divlo, wr_divhi;
    logic [15:0] div_q, div_eff, half;
    logic [1:0]  ctrl_q;
    logic        overrun_q, tx_drop_q;
    logic [7:0]  status, rd_mux;

    logic [7:0]  tx_head, rx_head;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [FIFO_DEPTH_LOG2:0] tx_count, rx_count;
    logic        unused_counts;

    uart_state_e tx_state, rx_state;
    logic [15:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_shift, rx_shift;
    logic        tx_q, tx_busy, tx_pop, tx_push_ok;
    logic        rx_s1, rx_s2, rx_prev, rx_push, rx_pop;

    assign sel       = (address[15:8] == PAGE);
    assign offset    = address[1:0];
    // A write held over several cycles at one address fires once.
    assign wstb      = we & sel & (!we_q | (address != addr_q));
    assign wr_data   = wstb & (offset == REG_DATA);
    assign wr_status = wstb & (offset == REG_STATUS);
    assign wr_divlo  = wstb & (offset == REG_DIVLO);
    assign wr_divhi  = wstb & (offset == REG_DIVHI);

    assign div_eff = eff_div(div_q);
    assign half    = div_eff >> 1;

    assign tx         = tx_q;
    assign tx_busy    = (tx_state != StIdle);
    assign tx_pop     = !tx_empty & ((tx_state == StIdle) |
                                     ((tx_state == StStop) & (tx_cnt == '0)));
    assign tx_push_ok = !tx_full | tx_pop;
    assign rx_push    = (rx_state == StStop) & (rx_cnt == '0) & rx_s2;
    assign rx_pop     = wr_status & o_data[0];
    assign irq        = (ctrl_q[1] & !rx_empty) | (ctrl_q[0] & tx_empty & !tx_busy);
    assign unused_counts = ^{tx_count, rx_count};

    uart_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_data & tx_push_ok),
        .wdata (o_data),
        .pop   (tx_pop),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    uart_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .wdata (rx_shift),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_OVERRUN]  = overrun_q;
        status[ST_TX_BUSY]  = tx_busy;
        status[ST_TX_DROP]  = tx_drop_q;
        unique case (offset)
            REG_DATA:   rd_mux = rx_empty ? 8'h00 : rx_head;
            REG_STATUS: rd_mux = status;
            REG_DIVLO:  rd_mux = div_q[7:0];
            REG_DIVHI:  rd_mux = div_q[15:8];
            default:    rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            hit       <= 1'b0;
            rdata     <= '0;
            div_q     <= DIV_RESET;
            ctrl_q    <= '0;
            overrun_q <= 1'b0;
            tx_drop_q <= 1'b0;
        end else begin
            we_q   <= we;
            addr_q <= address;
            hit    <= sel;
            rdata  <= rd_mux;
            if (wr_divlo) div_q[7:0] <= o_data;
            if (wr_divhi) begin
                div_q[15:8] <= o_data;
                ctrl_q      <= o_data[7:6];
            end
            // A same-cycle CPU pop makes room, so no overrun then.
            if (rx_push & rx_full & !rx_pop)      overrun_q <= 1'b1;
            else if (wr_status & o_data[4])       overrun_q <= 1'b0;
            if (wr_data & !tx_push_ok)            tx_drop_q <= 1'b1;
            else if (wr_status & o_data[6])       tx_drop_q <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state <= StIdle;
            tx_q     <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            unique case (tx_state)
                StIdle: if (!tx_empty) begin
                    tx_state <= StStart;
                    tx_q     <= 1'b0;
                    tx_cnt   <= div_eff - 16'd1;
                    tx_shift <= tx_head;
                end
                StStart: if (tx_cnt == '0) begin
                    tx_state <= StData;
                    tx_q     <= tx_shift[0];
                    tx_cnt   <= div_eff - 16'd1;
                    tx_bit   <= '0;
                end else tx_cnt <= tx_cnt - 16'd1;
                StData: if (tx_cnt == '0) begin
                    tx_cnt <= div_eff - 16'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state <= StStop;
                        tx_q     <= 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_shift <= tx_shift >> 1;
                        tx_q     <= tx_shift[1];
                    end
                end else tx_cnt <= tx_cnt - 16'd1;
                StStop: if (tx_cnt == '0) begin
                    if (!tx_empty) begin
                        tx_state <= StStart;
                        tx_q     <= 1'b0;
                        tx_cnt   <= div_eff - 16'd1;
                        tx_shift <= tx_head;
                    end else tx_state <= StIdle;
                end else tx_cnt <= tx_cnt - 16'd1;
                default: tx_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= StIdle;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            unique case (rx_state)
                StIdle: if (rx_prev & !rx_s2) begin
                    rx_state <= StStart;
                    rx_cnt   <= half - 16'd1;
                end
                StStart: if (rx_cnt == '0) begin
                    rx_state <= rx_s2 ? StIdle : StData;
                    rx_cnt   <= div_eff - 16'd1;
                    rx_bit   <= '0;
                end else rx_cnt <= rx_cnt - 16'd1;
                StData: if (rx_cnt == '0) begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_cnt   <= div_eff - 16'd1;
                    if (rx_bit == 3'd7) rx_state <= StStop;
                    else rx_bit <= rx_bit + 3'd1;
                end else rx_cnt <= rx_cnt - 16'd1;
                StStop: if (rx_cnt == '0) rx_state <= StIdle;
                        else rx_cnt <= rx_cnt - 16'd1;
                default: rx_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_uart_mmio.sv
// Directed bench for z80_uart_mmio: register-access vector table plus serial sequences.
module tb_z80_uart_mmio;

    logic        clock = 1'b0;
    logic        reset, we, rx;
    logic [15:0] address;
    logic [7:0]  o_data;
    logic [7:0]  rdata;
    logic        hit, tx, irq;

    int n_checks = 0;
    int n_fail   = 0;

    z80_uart_mmio dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .o_data  (o_data),
        .we      (we),
        .rdata   (rdata),
        .hit     (hit),
        .tx      (tx),
        .rx      (rx),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        wen;
        logic [7:0]  exp_rdata;
        logic        exp_hit;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int cycles);
        @(negedge clock);
        address = a;
        o_data  = d;
        we      = 1'b1;
        repeat (cycles) @(negedge clock);
        we = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
        @(negedge clock);
        address = a;
        we      = 1'b0;
        @(negedge clock);
        check(name, {8'h00, rdata}, {8'h00, exp});
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (4) @(negedge clock);
        end
        rx = 1'b1;
    endtask

    task automatic wait_tx_low(output logic ok);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        ok = (tx === 1'b0);
    endtask

    // Every clock of the frame is checked, so bit widths are exact (divisor 4).
    task automatic check_frame_exact(input logic [7:0] b);
        logic [9:0] bits;
        logic [3:0] nib;
        logic       ok;
        bits = {1'b1, b, 1'b0};
        wait_tx_low(ok);
        check("tx_frame_start", {15'd0, ok}, 16'd1);
        if (ok) begin
            for (int i = 0; i < 10; i++) begin
                for (int j = 0; j < 4; j++) begin
                    nib[j] = tx;
                    @(negedge clock);
                end
                check($sformatf("tx_bit%0d", i), {12'd0, nib}, {12'd0, {4{bits[i]}}});
            end
        end
    endtask

    task automatic get_tx_byte(output logic [7:0] b, output logic ok);
        wait_tx_low(ok);
        b = '0;
        if (ok) begin
            repeat (2) @(negedge clock);
            for (int k = 0; k < 8; k++) begin
                repeat (4) @(negedge clock);
                b[k] = tx;
            end
            repeat (4) @(negedge clock);
            ok = (tx === 1'b1);
        end
    endtask

    task automatic check_no_frame(input string name);
        logic saw_low;
        saw_low = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (tx === 1'b0) saw_low = 1'b1;
        end
        check(name, {15'd0, saw_low}, 16'd0);
    endtask

    initial begin
        logic [7:0] got;
        logic       ok;
        logic [7:0] rx_bytes [5];
        logic [7:0] tx_bytes [6];

        vecs[0]  = '{16'hFF01, 8'h00, 1'b0, 8'h06, 1'b1, 1'b0};
        vecs[1]  = '{16'h1234, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{16'hFF02, 8'h04, 1'b1, 8'hD9, 1'b1, 1'b0};
        vecs[3]  = '{16'hFF03, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{16'hFF02, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0};
        vecs[5]  = '{16'hFF03, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{16'hFF06, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0};
        vecs[7]  = '{16'hFE01, 8'h00, 1'b0, 8'h06, 1'b0, 1'b0};
        vecs[8]  = '{16'hFF03, 8'h40, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[9]  = '{16'hFF03, 8'h00, 1'b0, 8'h40, 1'b1, 1'b1};
        vecs[10] = '{16'hFF01, 8'h51, 1'b1, 8'h06, 1'b1, 1'b1};
        vecs[11] = '{16'hFF03, 8'h00, 1'b1, 8'h40, 1'b1, 1'b0};
        vecs[12] = '{16'hFF00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        rx_bytes = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h99};
        tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        reset   = 1'b1;
        we      = 1'b0;
        rx      = 1'b1;
        address = '0;
        o_data  = '0;
        #1;
        check("reset_tx", {15'd0, tx}, 16'd1);
        check("reset_hit", {15'd0, hit}, 16'd0);
        check("reset_rdata", {8'd0, rdata}, 16'd0);
        check("reset_irq", {15'd0, irq}, 16'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Register access table; leaves divisor = 4 and CTRL = 0.
        for (int i = 0; i < 13; i++) begin
            address = vecs[i].addr;
            o_data  = vecs[i].wdata;
            we      = vecs[i].wen;
            @(negedge clock);
            check($sformatf("vec%0d_rdata", i), {8'd0, rdata}, {8'd0, vecs[i].exp_rdata});
            check($sformatf("vec%0d_hit", i), {15'd0, hit}, {15'd0, vecs[i].exp_hit});
            check($sformatf("vec%0d_irq", i), {15'd0, irq}, {15'd0, vecs[i].exp_irq});
        end
        we = 1'b0;

        // Write held for 3 cycles sends exactly one frame.
        fork
            wr(16'hFF00, 8'hA5, 3);
            check_frame_exact(8'hA5);
        join
        check_no_frame("tx_single_frame");
        rd_check("status_tx_done", 16'hFF01, 8'h06);

        send_rx(8'h3C, 1'b1);
        repeat (3) @(negedge clock);
        rd_check("status_rx_one", 16'hFF01, 8'h02);
        rd_check("rx_data_3c", 16'hFF00, 8'h3C);
        wr(16'hFF01, 8'h01, 1);
        rd_check("status_rx_popped", 16'hFF01, 8'h06);

        send_rx(8'h55, 1'b0);
        repeat (3) @(negedge clock);
        rd_check("status_framing_err", 16'hFF01, 8'h06);

        for (int i = 0; i < 5; i++) send_rx(rx_bytes[i], 1'b1);
        repeat (3) @(negedge clock);
        rd_check("status_overrun", 16'hFF01, 8'h1A);
        wr(16'hFF01, 8'h10, 1);
        rd_check("status_overrun_clr", 16'hFF01, 8'h0A);
        for (int i = 0; i < 4; i++) begin
            rd_check($sformatf("rx_fifo%0d", i), 16'hFF00, rx_bytes[i]);
            wr(16'hFF01, 8'h01, 1);
        end
        rd_check("status_rx_drained", 16'hFF01, 8'h06);

        @(negedge clock);
        rx = 1'b0;
        @(negedge clock);
        rx = 1'b1;
        repeat (20) @(negedge clock);
        rd_check("status_glitch", 16'hFF01, 8'h06);

        // Six writes while draining: one in the shifter, four queued, one dropped.
        fork
            begin
                for (int i = 0; i < 6; i++) wr(16'hFF00, tx_bytes[i], 1);
                rd_check("status_tx_full", 16'hFF01, 8'h65);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    get_tx_byte(got, ok);
                    check($sformatf("tx_frame%0d_ok", i), {15'd0, ok}, 16'd1);
                    check($sformatf("tx_frame%0d_byte", i), {8'd0, got}, {8'd0, tx_bytes[i]});
                end
            end
        join
        check_no_frame("tx_no_sixth");
        rd_check("status_tx_drop", 16'hFF01, 8'h46);
        wr(16'hFF01, 8'h40, 1);
        rd_check("status_drop_clr", 16'hFF01, 8'h06);

        wr(16'hFF00, 8'hF0, 1);
        wr(16'hFF00, 8'h0F, 1);
        wait_tx_low(ok);
        repeat (6) @(negedge clock);
        check("tx_low_before_reset", {15'd0, tx}, 16'd0);
        #2 reset = 1'b1;
        #1 check("tx_high_on_reset", {15'd0, tx}, 16'd1);
        @(negedge clock);
        reset = 1'b0;
        rd_check("status_after_reset", 16'hFF01, 8'h06);
        rd_check("divlo_after_reset", 16'hFF02, 8'hD9);
        check_no_frame("tx_idle_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
